// File: rtl/cci_mpf_shim_mdata_tag_pkg.sv
// Shared CCI MPF constants used by the Mdata tagging shim and its tag pools.
//   CCI_MDATA_WIDTH : width of the Mdata field, held in header bits [15:0]
//   CCI_REQ_HDR_W   : request header width (channels 0 and 1)
//   CCI_RSP_HDR_W   : response header width (rx channels 0 and 1)
//   CCI_DATA_W      : cache-line data width
package cci_mpf_shim_mdata_tag_pkg;

  localparam int unsigned CCI_MDATA_WIDTH = 16;
  localparam int unsigned CCI_REQ_HDR_W   = 74;
  localparam int unsigned CCI_RSP_HDR_W   = 28;
  localparam int unsigned CCI_DATA_W      = 512;

endpackage

// File: rtl/cci_mpf_prim_tag_pool.sv
// Tag pool: free bitmap, lowest-index allocator, free counter and Mdata table.
//   clk, reset                 : clock, synchronous active-high reset
//   i_alloc / i_alloc_mdata    : allocate o_alloc_tag and remember the Mdata
//   o_alloc_tag                : lowest free tag (valid when o_free_cnt != 0)
//   i_free0/1, i_free0/1_tag   : two independent free ports
//   i_rd0/1_tag, o_rd0/1_mdata : combinational table lookups
//   o_free_cnt                 : number of free tags
module cci_mpf_prim_tag_pool
  import cci_mpf_shim_mdata_tag_pkg::*;
#(
  parameter int unsigned N_TAGS = 64,
  localparam int unsigned TAG_W = $clog2(N_TAGS),
  localparam int unsigned CNT_W = TAG_W + 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       i_alloc,
  input  logic [CCI_MDATA_WIDTH-1:0] i_alloc_mdata,
  output logic [TAG_W-1:0]           o_alloc_tag,
  input  logic                       i_free0,
  input  logic [TAG_W-1:0]           i_free0_tag,
  input  logic                       i_free1,
  input  logic [TAG_W-1:0]           i_free1_tag,
  input  logic [TAG_W-1:0]           i_rd0_tag,
  output logic [CCI_MDATA_WIDTH-1:0] o_rd0_mdata,
  input  logic [TAG_W-1:0]           i_rd1_tag,
  output logic [CCI_MDATA_WIDTH-1:0] o_rd1_mdata,
  output logic [CNT_W-1:0]           o_free_cnt
);

  logic [N_TAGS-1:0]          r_free;
  logic [N_TAGS-1:0]          w_free_nxt;
  logic [CNT_W-1:0]           r_cnt;
  logic [CNT_W-1:0]           w_cnt_nxt;
  logic [TAG_W-1:0]           w_alloc_tag;
  logic [CCI_MDATA_WIDTH-1:0] r_tbl [N_TAGS];

  // Priority encoder over the registered bitmap only, so a tag freed this
  // cycle becomes allocatable one cycle later.
  always_comb begin
    w_alloc_tag = '0;
    for (int i = N_TAGS - 1; i >= 0; i--) begin
      if (r_free[i]) w_alloc_tag = TAG_W'(i);
    end
  end

  // A freed tag is always a busy tag, so it can never collide with the
  // tag being allocated in the same cycle.
  always_comb begin
    w_free_nxt = r_free;
    if (i_alloc) w_free_nxt[w_alloc_tag] = 1'b0;
    if (i_free0) w_free_nxt[i_free0_tag] = 1'b1;
    if (i_free1) w_free_nxt[i_free1_tag] = 1'b1;
  end

  assign w_cnt_nxt = r_cnt + CNT_W'(i_free0) + CNT_W'(i_free1) - CNT_W'(i_alloc);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_free <= '1;
      r_cnt  <= CNT_W'(N_TAGS);
    end else begin
      r_free <= w_free_nxt;
      r_cnt  <= w_cnt_nxt;
    end
  end

  // Table needs no reset: entries are only read for busy tags.
  always_ff @(posedge clk) begin
    if (i_alloc) r_tbl[w_alloc_tag] <= i_alloc_mdata;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (!(i_alloc && (r_cnt == '0)))
        else $fatal(1, "tag pool: request with no free tag");
      assert (!(i_free0 && r_free[i_free0_tag]))
        else $fatal(1, "tag pool: response names free tag %0d", i_free0_tag);
      assert (!(i_free1 && r_free[i_free1_tag]))
        else $fatal(1, "tag pool: response names free tag %0d", i_free1_tag);
      assert (!(i_free0 && i_free1 && (i_free0_tag == i_free1_tag)))
        else $fatal(1, "tag pool: tag %0d freed twice", i_free0_tag);
    end
  end

  assign o_alloc_tag = w_alloc_tag;
  assign o_rd0_mdata = r_tbl[i_rd0_tag];
  assign o_rd1_mdata = r_tbl[i_rd1_tag];
  assign o_free_cnt  = r_cnt;

endmodule

// File: rtl/cci_mpf_shim_mdata_tag.sv
// Mdata tagging shim between an AFU and one multiplexer port. Requests have
// Mdata replaced by a zero-extended tag (registered, 1 cycle); responses get
// the original Mdata back combinationally. Separate pools for reads (R) and
// writes (W); almost-full is forced when a pool runs low.
//   afu_c0_*/afu_c1_*   : AFU requests in, almost-full out
//   fiu_c0_*/fiu_c1_*   : tagged requests out, downstream almost-full in
//   fiu_rx0_*/fiu_rx1_* : responses in (tagged)
//   afu_rx0_*/afu_rx1_* : responses out (original Mdata restored)
module cci_mpf_shim_mdata_tag
  import cci_mpf_shim_mdata_tag_pkg::*;
#(
  parameter int unsigned N_TAGS             = 64,
  parameter int unsigned ALMFULL_SLACK      = 8,
  parameter int unsigned RESERVED_MDATA_IDX = 15
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     afu_c0_valid,
  input  logic [CCI_REQ_HDR_W-1:0] afu_c0_hdr,
  output logic                     afu_c0_almfull,
  input  logic                     afu_c1_valid,
  input  logic [CCI_REQ_HDR_W-1:0] afu_c1_hdr,
  input  logic [CCI_DATA_W-1:0]    afu_c1_data,
  output logic                     afu_c1_almfull,
  output logic                     fiu_c0_valid,
  output logic [CCI_REQ_HDR_W-1:0] fiu_c0_hdr,
  input  logic                     fiu_c0_almfull,
  output logic                     fiu_c1_valid,
  output logic [CCI_REQ_HDR_W-1:0] fiu_c1_hdr,
  output logic [CCI_DATA_W-1:0]    fiu_c1_data,
  input  logic                     fiu_c1_almfull,
  input  logic                     fiu_rx0_rdvalid,
  input  logic                     fiu_rx0_wrvalid,
  input  logic [CCI_RSP_HDR_W-1:0] fiu_rx0_hdr,
  input  logic [CCI_DATA_W-1:0]    fiu_rx0_data,
  input  logic                     fiu_rx1_wrvalid,
  input  logic [CCI_RSP_HDR_W-1:0] fiu_rx1_hdr,
  output logic                     afu_rx0_rdvalid,
  output logic                     afu_rx0_wrvalid,
  output logic [CCI_RSP_HDR_W-1:0] afu_rx0_hdr,
  output logic [CCI_DATA_W-1:0]    afu_rx0_data,
  output logic                     afu_rx1_wrvalid,
  output logic [CCI_RSP_HDR_W-1:0] afu_rx1_hdr
);

  localparam int unsigned TAG_W = $clog2(N_TAGS);
  localparam int unsigned CNT_W = TAG_W + 1;
  localparam int unsigned PAD_W = CCI_MDATA_WIDTH - TAG_W;

  logic [TAG_W-1:0]           w_r_tag, w_w_tag;
  logic [CNT_W-1:0]           w_r_free_cnt, w_w_free_cnt;
  logic [TAG_W-1:0]           w_rx0_tag, w_rx1_tag;
  logic [CCI_MDATA_WIDTH-1:0] w_r_rd_mdata, w_w_rd0_mdata, w_w_rd1_mdata;
  logic [CCI_MDATA_WIDTH-1:0] w_unused_r_rd1_mdata;
  logic [2*PAD_W-1:0]         w_unused_rsp_bits;

  logic                       r_c0_valid, r_c1_valid;
  logic [CCI_REQ_HDR_W-1:0]   r_c0_hdr, r_c1_hdr;
  logic [CCI_DATA_W-1:0]      r_c1_data;
  logic                       r_c0_almfull, r_c1_almfull;

  assign w_rx0_tag         = fiu_rx0_hdr[TAG_W-1:0];
  assign w_rx1_tag         = fiu_rx1_hdr[TAG_W-1:0];
  // Response Mdata bits above the tag carry nothing once tagged.
  assign w_unused_rsp_bits = {fiu_rx0_hdr[CCI_MDATA_WIDTH-1:TAG_W],
                              fiu_rx1_hdr[CCI_MDATA_WIDTH-1:TAG_W]};

  cci_mpf_prim_tag_pool #(.N_TAGS(N_TAGS)) u_pool_r (
    .clk          (clk),
    .reset        (reset),
    .i_alloc      (afu_c0_valid),
    .i_alloc_mdata(afu_c0_hdr[CCI_MDATA_WIDTH-1:0]),
    .o_alloc_tag  (w_r_tag),
    .i_free0      (fiu_rx0_rdvalid),
    .i_free0_tag  (w_rx0_tag),
    .i_free1      (1'b0),
    .i_free1_tag  (w_rx1_tag),
    .i_rd0_tag    (w_rx0_tag),
    .o_rd0_mdata  (w_r_rd_mdata),
    .i_rd1_tag    (w_rx1_tag),
    .o_rd1_mdata  (w_unused_r_rd1_mdata),
    .o_free_cnt   (w_r_free_cnt)
  );

  // Write acks may arrive on either rx channel, possibly in the same cycle.
  cci_mpf_prim_tag_pool #(.N_TAGS(N_TAGS)) u_pool_w (
    .clk          (clk),
    .reset        (reset),
    .i_alloc      (afu_c1_valid),
    .i_alloc_mdata(afu_c1_hdr[CCI_MDATA_WIDTH-1:0]),
    .o_alloc_tag  (w_w_tag),
    .i_free0      (fiu_rx0_wrvalid),
    .i_free0_tag  (w_rx0_tag),
    .i_free1      (fiu_rx1_wrvalid),
    .i_free1_tag  (w_rx1_tag),
    .i_rd0_tag    (w_rx0_tag),
    .o_rd0_mdata  (w_w_rd0_mdata),
    .i_rd1_tag    (w_rx1_tag),
    .o_rd1_mdata  (w_w_rd1_mdata),
    .o_free_cnt   (w_w_free_cnt)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_c0_valid   <= 1'b0;
      r_c1_valid   <= 1'b0;
      r_c0_almfull <= 1'b1;
      r_c1_almfull <= 1'b1;
    end else begin
      r_c0_valid   <= afu_c0_valid;
      r_c1_valid   <= afu_c1_valid;
      r_c0_almfull <= fiu_c0_almfull || (w_r_free_cnt <= CNT_W'(ALMFULL_SLACK));
      r_c1_almfull <= fiu_c1_almfull || (w_w_free_cnt <= CNT_W'(ALMFULL_SLACK));
    end
  end

  always_ff @(posedge clk) begin
    r_c0_hdr  <= {afu_c0_hdr[CCI_REQ_HDR_W-1:CCI_MDATA_WIDTH], {PAD_W{1'b0}}, w_r_tag};
    r_c1_hdr  <= {afu_c1_hdr[CCI_REQ_HDR_W-1:CCI_MDATA_WIDTH], {PAD_W{1'b0}}, w_w_tag};
    r_c1_data <= afu_c1_data;
  end

  // The multiplexer's routing bit must always leave this shim as zero.
  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (!(r_c0_valid && r_c0_hdr[RESERVED_MDATA_IDX]))
        else $fatal(1, "mdata tag: reserved bit set on read");
      assert (!(r_c1_valid && r_c1_hdr[RESERVED_MDATA_IDX]))
        else $fatal(1, "mdata tag: reserved bit set on write");
    end
  end

  assign fiu_c0_valid   = r_c0_valid;
  assign fiu_c0_hdr     = r_c0_hdr;
  assign fiu_c1_valid   = r_c1_valid;
  assign fiu_c1_hdr     = r_c1_hdr;
  assign fiu_c1_data    = r_c1_data;
  assign afu_c0_almfull = r_c0_almfull;
  assign afu_c1_almfull = r_c1_almfull;

  assign afu_rx0_rdvalid = fiu_rx0_rdvalid;
  assign afu_rx0_wrvalid = fiu_rx0_wrvalid;
  assign afu_rx0_data    = fiu_rx0_data;
  assign afu_rx0_hdr     = {fiu_rx0_hdr[CCI_RSP_HDR_W-1:CCI_MDATA_WIDTH],
                            fiu_rx0_rdvalid ? w_r_rd_mdata : w_w_rd0_mdata};
  assign afu_rx1_wrvalid = fiu_rx1_wrvalid;
  assign afu_rx1_hdr     = {fiu_rx1_hdr[CCI_RSP_HDR_W-1:CCI_MDATA_WIDTH], w_w_rd1_mdata};

endmodule

// File: tb/tb_cci_mpf_shim_mdata_tag.sv
module tb_cci_mpf_shim_mdata_tag;
  import cci_mpf_shim_mdata_tag_pkg::*;

  localparam logic [CCI_REQ_HDR_W-17:0] REQ_UP = 58'h2A55A5AC3C30F0F;
  localparam logic [CCI_RSP_HDR_W-17:0] RSP_UP = 12'hA5C;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic                     afu_c0_valid, afu_c0_almfull, afu_c1_valid, afu_c1_almfull;
  logic [CCI_REQ_HDR_W-1:0] afu_c0_hdr, afu_c1_hdr, fiu_c0_hdr, fiu_c1_hdr;
  logic [CCI_DATA_W-1:0]    afu_c1_data, fiu_c1_data, fiu_rx0_data, afu_rx0_data;
  logic                     fiu_c0_valid, fiu_c0_almfull, fiu_c1_valid, fiu_c1_almfull;
  logic                     fiu_rx0_rdvalid, fiu_rx0_wrvalid, fiu_rx1_wrvalid;
  logic [CCI_RSP_HDR_W-1:0] fiu_rx0_hdr, fiu_rx1_hdr, afu_rx0_hdr, afu_rx1_hdr;
  logic                     afu_rx0_rdvalid, afu_rx0_wrvalid, afu_rx1_wrvalid;

  cci_mpf_shim_mdata_tag dut (
    .clk(clk), .reset(reset),
    .afu_c0_valid(afu_c0_valid), .afu_c0_hdr(afu_c0_hdr), .afu_c0_almfull(afu_c0_almfull),
    .afu_c1_valid(afu_c1_valid), .afu_c1_hdr(afu_c1_hdr), .afu_c1_data(afu_c1_data),
    .afu_c1_almfull(afu_c1_almfull),
    .fiu_c0_valid(fiu_c0_valid), .fiu_c0_hdr(fiu_c0_hdr), .fiu_c0_almfull(fiu_c0_almfull),
    .fiu_c1_valid(fiu_c1_valid), .fiu_c1_hdr(fiu_c1_hdr), .fiu_c1_data(fiu_c1_data),
    .fiu_c1_almfull(fiu_c1_almfull),
    .fiu_rx0_rdvalid(fiu_rx0_rdvalid), .fiu_rx0_wrvalid(fiu_rx0_wrvalid),
    .fiu_rx0_hdr(fiu_rx0_hdr), .fiu_rx0_data(fiu_rx0_data),
    .fiu_rx1_wrvalid(fiu_rx1_wrvalid), .fiu_rx1_hdr(fiu_rx1_hdr),
    .afu_rx0_rdvalid(afu_rx0_rdvalid), .afu_rx0_wrvalid(afu_rx0_wrvalid),
    .afu_rx0_hdr(afu_rx0_hdr), .afu_rx0_data(afu_rx0_data),
    .afu_rx1_wrvalid(afu_rx1_wrvalid), .afu_rx1_hdr(afu_rx1_hdr)
  );

  typedef struct {
    logic c0_v; logic [15:0] c0_md;
    logic c1_v; logic [15:0] c1_md;
    logic rx0_rd; logic rx0_wr; logic [7:0] rx0_tag;
    logic rx1_wr; logic [7:0] rx1_tag;
    logic e_c0_v; logic [7:0] e_c0_tag;
    logic e_c1_v; logic [7:0] e_c1_tag;
    logic [15:0] e_rx0_md; logic [15:0] e_rx1_md;
  } vec_t;

  vec_t vecs [17];
  int n_vec = 0;
  int n_miss = 0;

  task automatic chk(input string nm, input logic [511:0] got, input logic [511:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic drive(input logic c0v, input logic [15:0] c0md, input logic c1v,
                       input logic [15:0] c1md, input logic rd, input logic wr,
                       input logic [7:0] t0, input logic w1, input logic [7:0] t1);
    afu_c0_valid    = c0v;
    afu_c0_hdr      = {REQ_UP, c0md};
    afu_c1_valid    = c1v;
    afu_c1_hdr      = {REQ_UP, c1md};
    afu_c1_data     = {32{c1md}};
    fiu_rx0_rdvalid = rd;
    fiu_rx0_wrvalid = wr;
    fiu_rx0_hdr     = {RSP_UP, 8'h00, t0};
    fiu_rx0_data    = {64{t0}};
    fiu_rx1_wrvalid = w1;
    fiu_rx1_hdr     = {RSP_UP, 8'h00, t1};
  endtask

  task automatic idle();
    drive(1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 1'b0, 8'd0, 1'b0, 8'd0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
  endtask

  function automatic int lowest(input logic [63:0] fr);
    for (int j = 0; j < 64; j++) if (fr[j]) return j;
    return -1;
  endfunction

  function automatic int pick_busy(input logic [63:0] fr, input int start, input int avoid);
    for (int j = 0; j < 64; j++) begin
      int idx;
      idx = (start + j) % 64;
      if (!fr[idx] && idx != avoid) return idx;
    end
    return -1;
  endfunction

  logic [63:0] m_rfree, m_wfree;
  logic [15:0] m_rmd [64];
  logic [15:0] m_wmd [64];

  initial begin
    logic [15:0] prev_c1_md;
    logic        pend_c0_v, pend_c1_v;
    int          pend_c0_tag, pend_c1_tag;

    //                c0        c1         rd    wr    t0     w1    t1     ec0         ec1         erx0     erx1
    vecs[0]  = '{1'b1, 16'hBEEF, 1'b0, 16'h0000, 1'b0, 1'b0, 8'd0, 1'b0, 8'd0, 1'b0, 8'd0, 1'b0, 8'd0, 16'h0000, 16'h0000};
    vecs[1]  = '{1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 1'b0, 8'd0, 1'b0, 8'd0, 1'b1, 8'd0, 1'b0, 8'd0, 16'hBEEF, 16'h0000};
    vecs[2]  = '{1'b1, 16'h1111, 1'b0, 16'h0000, 1'b0, 1'b0, 8'd0, 1'b0, 8'd0, 1'b0, 8'd0, 1'b0, 8'd0, 16'h0000, 16'h0000};
    vecs[3]  = '{1'b1, 16'h2222, 1'b0, 16'h0000, 1'b1, 1'b0, 8'd0, 1'b0, 8'd0, 1'b1, 8'd0, 1'b0, 8'd0, 16'h1111, 16'h0000};
    vecs[4]  = '{1'b1, 16'h3333, 1'b0, 16'h0000, 1'b0, 1'b0, 8'd0, 1'b0, 8'd0, 1'b1, 8'd1, 1'b0, 8'd0, 16'h0000, 16'h0000};
    vecs[5]  = '{1'b0, 16'h0000, 1'b1, 16'hAAAA, 1'b0, 1'b0, 8'd0, 1'b0, 8'd0, 1'b1, 8'd0, 1'b0, 8'd0, 16'h0000, 16'h0000};
    vecs[6]  = '{1'b0, 16'h0000, 1'b1, 16'hBBBB, 1'b0, 1'b0, 8'd0, 1'b0, 8'd0, 1'b0, 8'd0, 1'b1, 8'd0, 16'h0000, 16'h0000};
    vecs[7]  = '{1'b0, 16'h0000, 1'b1, 16'hCCCC, 1'b0, 1'b0, 8'd0, 1'b0, 8'd0, 1'b0, 8'd0, 1'b1, 8'd1, 16'h0000, 16'h0000};
    vecs[8]  = '{1'b0, 16'h0000, 1'b1, 16'hDDDD, 1'b0, 1'b0, 8'd0, 1'b0, 8'd0, 1'b0, 8'd0, 1'b1, 8'd2, 16'h0000, 16'h0000};
    vecs[9]  = '{1'b0, 16'h0000, 1'b1, 16'hEEEE, 1'b0, 1'b0, 8'd0, 1'b0, 8'd0, 1'b0, 8'd0, 1'b1, 8'd3, 16'h0000, 16'h0000};
    vecs[10] = '{1'b0, 16'h0000, 1'b1, 16'hFFFF, 1'b0, 1'b0, 8'd0, 1'b0, 8'd0, 1'b0, 8'd0, 1'b1, 8'd4, 16'h0000, 16'h0000};
    vecs[11] = '{1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b1, 8'd3, 1'b1, 8'd5, 1'b0, 8'd0, 1'b1, 8'd5, 16'hDDDD, 16'hFFFF};
    vecs[12] = '{1'b0, 16'h0000, 1'b1, 16'h0101, 1'b1, 1'b0, 8'd1, 1'b0, 8'd0, 1'b0, 8'd0, 1'b0, 8'd0, 16'h2222, 16'h0000};
    vecs[13] = '{1'b0, 16'h0000, 1'b1, 16'h0202, 1'b1, 1'b0, 8'd0, 1'b0, 8'd0, 1'b0, 8'd0, 1'b1, 8'd3, 16'h3333, 16'h0000};
    vecs[14] = '{1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 8'd0, 1'b0, 8'd0, 1'b0, 8'd0, 1'b1, 8'd5, 16'h0000, 16'h0000};
    vecs[15] = '{1'b1, 16'h4444, 1'b0, 16'h0000, 1'b0, 1'b1, 8'd5, 1'b1, 8'd3, 1'b0, 8'd0, 1'b0, 8'd0, 16'h0202, 16'h0101};
    vecs[16] = '{1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 8'd0, 1'b0, 8'd0, 1'b1, 8'd0, 1'b0, 8'd0, 16'h0000, 16'h0000};

    fiu_c0_almfull = 1'b0;
    fiu_c1_almfull = 1'b0;
    idle();
    repeat (2) tick();
    chk("reset c0_valid", 512'(fiu_c0_valid), 512'(1'b0));
    chk("reset c1_valid", 512'(fiu_c1_valid), 512'(1'b0));
    chk("reset c0_almfull", 512'(afu_c0_almfull), 512'(1'b1));
    chk("reset c1_almfull", 512'(afu_c1_almfull), 512'(1'b1));
    chk("reset r_cnt", 512'(dut.w_r_free_cnt), 512'(64));
    chk("reset w_cnt", 512'(dut.w_w_free_cnt), 512'(64));
    reset = 1'b0;

    // Directed table
    prev_c1_md = 16'h0;
    for (int i = 0; i < 17; i++) begin
      drive(vecs[i].c0_v, vecs[i].c0_md, vecs[i].c1_v, vecs[i].c1_md, vecs[i].rx0_rd,
            vecs[i].rx0_wr, vecs[i].rx0_tag, vecs[i].rx1_wr, vecs[i].rx1_tag);
      #1;
      chk($sformatf("v%0d c0_valid", i), 512'(fiu_c0_valid), 512'(vecs[i].e_c0_v));
      if (vecs[i].e_c0_v)
        chk($sformatf("v%0d c0_hdr", i), 512'(fiu_c0_hdr), 512'({REQ_UP, 8'h00, vecs[i].e_c0_tag}));
      chk($sformatf("v%0d c1_valid", i), 512'(fiu_c1_valid), 512'(vecs[i].e_c1_v));
      if (vecs[i].e_c1_v) begin
        chk($sformatf("v%0d c1_hdr", i), 512'(fiu_c1_hdr), 512'({REQ_UP, 8'h00, vecs[i].e_c1_tag}));
        chk($sformatf("v%0d c1_data", i), fiu_c1_data, {32{prev_c1_md}});
      end
      chk($sformatf("v%0d rx0_rdvalid", i), 512'(afu_rx0_rdvalid), 512'(vecs[i].rx0_rd));
      chk($sformatf("v%0d rx0_wrvalid", i), 512'(afu_rx0_wrvalid), 512'(vecs[i].rx0_wr));
      chk($sformatf("v%0d rx1_wrvalid", i), 512'(afu_rx1_wrvalid), 512'(vecs[i].rx1_wr));
      if (vecs[i].rx0_rd || vecs[i].rx0_wr) begin
        chk($sformatf("v%0d rx0_hdr", i), 512'(afu_rx0_hdr), 512'({RSP_UP, vecs[i].e_rx0_md}));
        chk($sformatf("v%0d rx0_data", i), afu_rx0_data, {64{vecs[i].rx0_tag}});
      end
      if (vecs[i].rx1_wr)
        chk($sformatf("v%0d rx1_hdr", i), 512'(afu_rx1_hdr), 512'({RSP_UP, vecs[i].e_rx1_md}));
      if (i == 12) chk("w_cnt after dual free", 512'(dut.w_w_free_cnt), 512'(60));
      if (vecs[i].c1_v) prev_c1_md = vecs[i].c1_md;
      tick();
    end

    // Almost-full threshold and exhaustion of pool R
    do_reset();
    for (int k = 0; k < 57; k++) begin
      if (k == 56) chk("almfull before slack", 512'(afu_c0_almfull), 512'(1'b0));
      drive(1'b1, 16'(k), 1'b0, 16'h0, 1'b0, 1'b0, 8'd0, 1'b0, 8'd0);
      tick();
    end
    chk("almfull at slack", 512'(afu_c0_almfull), 512'(1'b1));
    chk("r_cnt at slack", 512'(dut.w_r_free_cnt), 512'(7));
    chk("c1 almfull idle", 512'(afu_c1_almfull), 512'(1'b0));
    for (int k = 0; k < 7; k++) begin
      drive(1'b1, 16'(100 + k), 1'b0, 16'h0, 1'b0, 1'b0, 8'd0, 1'b0, 8'd0);
      tick();
    end
    idle();
    #1;
    chk("last tag", 512'(fiu_c0_hdr), 512'({REQ_UP, 16'd63}));
    chk("r_cnt empty", 512'(dut.w_r_free_cnt), 512'(0));
    chk("almfull empty", 512'(afu_c0_almfull), 512'(1'b1));

    // Reset with outstanding tags, request and response held during reset
    do_reset();
    for (int k = 0; k < 20; k++) begin
      drive(1'b1, 16'(k), 1'b1, 16'(k + 50), 1'b0, 1'b0, 8'd0, 1'b0, 8'd0);
      tick();
    end
    reset = 1'b1;
    drive(1'b1, 16'h7777, 1'b1, 16'h8888, 1'b1, 1'b1, 8'd40, 1'b1, 8'd41);
    tick();
    chk("mid reset r_cnt", 512'(dut.w_r_free_cnt), 512'(64));
    chk("mid reset w_cnt", 512'(dut.w_w_free_cnt), 512'(64));
    chk("mid reset c0_valid", 512'(fiu_c0_valid), 512'(1'b0));
    chk("mid reset c1_valid", 512'(fiu_c1_valid), 512'(1'b0));
    chk("mid reset c0_almfull", 512'(afu_c0_almfull), 512'(1'b1));
    chk("mid reset c1_almfull", 512'(afu_c1_almfull), 512'(1'b1));
    idle();
    repeat (2) tick();
    chk("held reset c0_almfull", 512'(afu_c0_almfull), 512'(1'b1));
    reset = 1'b0;
    fiu_c1_almfull = 1'b1;
    tick();
    chk("post reset c0_almfull", 512'(afu_c0_almfull), 512'(1'b0));
    chk("fiu c1 almfull pass", 512'(afu_c1_almfull), 512'(1'b1));
    fiu_c1_almfull = 1'b0;
    drive(1'b1, 16'h5555, 1'b0, 16'h0, 1'b0, 1'b0, 8'd0, 1'b0, 8'd0);
    tick();
    idle();
    chk("c1 almfull release", 512'(afu_c1_almfull), 512'(1'b0));
    chk("post reset tag", 512'(fiu_c0_hdr), 512'({REQ_UP, 16'd0}));

    // Random interleaved traffic against a scoreboard
    do_reset();
    m_rfree = '1;
    m_wfree = '1;
    pend_c0_v = 1'b0;
    pend_c1_v = 1'b0;
    pend_c0_tag = 0;
    pend_c1_tag = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      int t0, t1, et0, et1, sel;
      logic rd, wr, w1, c0v, c1v;
      logic [15:0] md0, md1;
      chk($sformatf("rnd%0d c0_valid", cyc), 512'(fiu_c0_valid), 512'(pend_c0_v));
      if (pend_c0_v)
        chk($sformatf("rnd%0d c0_tag", cyc), 512'(fiu_c0_hdr[15:0]), 512'(pend_c0_tag));
      chk($sformatf("rnd%0d c1_valid", cyc), 512'(fiu_c1_valid), 512'(pend_c1_v));
      if (pend_c1_v)
        chk($sformatf("rnd%0d c1_tag", cyc), 512'(fiu_c1_hdr[15:0]), 512'(pend_c1_tag));
      rd = 1'b0; wr = 1'b0; w1 = 1'b0; t0 = 0; t1 = 0;
      sel = int'($urandom_range(0, 3));
      if (sel == 1) begin
        t0 = pick_busy(m_rfree, int'($urandom_range(0, 63)), -1);
        if (t0 >= 0) rd = 1'b1; else t0 = 0;
      end else if (sel == 2) begin
        t0 = pick_busy(m_wfree, int'($urandom_range(0, 63)), -1);
        if (t0 >= 0) wr = 1'b1; else t0 = 0;
      end
      if ($urandom_range(0, 1) == 1) begin
        t1 = pick_busy(m_wfree, int'($urandom_range(0, 63)), wr ? t0 : -1);
        if (t1 >= 0) w1 = 1'b1; else t1 = 0;
      end
      c0v = ($countones(m_rfree) > 4) && ($urandom_range(0, 9) < 6);
      c1v = ($countones(m_wfree) > 4) && ($urandom_range(0, 9) < 6);
      et0 = lowest(m_rfree);
      et1 = lowest(m_wfree);
      md0 = 16'($urandom);
      md1 = 16'($urandom);
      drive(c0v, md0, c1v, md1, rd, wr, 8'(t0), w1, 8'(t1));
      #1;
      if (rd) chk($sformatf("rnd%0d rx0 rd mdata", cyc), 512'(afu_rx0_hdr), 512'({RSP_UP, m_rmd[t0]}));
      if (wr) chk($sformatf("rnd%0d rx0 wr mdata", cyc), 512'(afu_rx0_hdr), 512'({RSP_UP, m_wmd[t0]}));
      if (w1) chk($sformatf("rnd%0d rx1 wr mdata", cyc), 512'(afu_rx1_hdr), 512'({RSP_UP, m_wmd[t1]}));
      if (c0v) begin m_rfree[et0] = 1'b0; m_rmd[et0] = md0; end
      if (c1v) begin m_wfree[et1] = 1'b0; m_wmd[et1] = md1; end
      if (rd) m_rfree[t0] = 1'b1;
      if (wr) m_wfree[t0] = 1'b1;
      if (w1) m_wfree[t1] = 1'b1;
      pend_c0_v = c0v; pend_c0_tag = et0;
      pend_c1_v = c1v; pend_c1_tag = et1;
      tick();
    end
    idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
